// File: rtl/rv32i_pkg.sv
// Shared RV32I types and widths used across the integer pipeline.
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       word_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set on
// accepted issue and cleared on writeback, with the writeback bypass hiding the hazard.
module reg_scoreboard #(
  parameter  int NREGS = 2 ** rv32i_pkg::REG_ADDR_W,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  input  logic          issue_en,
  input  logic [AW-1:0] issue_rd,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  output logic          rs1_busy,
  output logic          rs2_busy
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic             issue_accept;

  // A writeback to the source register this cycle resolves the hazard via bypass.
  assign rs1_busy = busy[rs1_addr] && !(wb_en && (wb_addr == rs1_addr));
  assign rs2_busy = busy[rs2_addr] && !(wb_en && (wb_addr == rs2_addr));

  // Acceptance deliberately ignores issue_en when forming the busy outputs,
  // so decode never sees a combinational path from issue_en back to hazard.
  assign issue_accept = issue_en && !(rs1_busy || rs2_busy);

  // NOTE: every always_comb output gets a full default first so no path
  // through the conditionals can leave it unassigned and infer a latch.
  always_comb begin
    busy_next = busy;
    if (wb_en) begin
      busy_next[wb_addr] = 1'b0;
    end
    // Set is applied after clear so a new producer wins over the retiring one.
    if (issue_accept) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: rtl/reg_file.sv
// RV32I architectural register file: two combinational read ports with
// writeback bypass, one synchronous write port, x0 tied to zero, RAW hazard flag.
module reg_file #(
  parameter  int XLEN  = rv32i_pkg::XLEN,
  parameter  int NREGS = 2 ** rv32i_pkg::REG_ADDR_W,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  output logic            hazard,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] regs [NREGS];
  logic            rs1_busy;
  logic            rs2_busy;

  // NOTE: the array is cleared on reset because software relies on registers
  // reading zero after reset; this keeps it as flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Priority: x0 forces zero, then same-cycle writeback, then stored value.
  always_comb begin
    rs1_data = regs[rs1_addr];
    if (wb_en && (wb_addr == rs1_addr)) begin
      rs1_data = wb_data;
    end
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end
  end

  always_comb begin
    rs2_data = regs[rs2_addr];
    if (wb_en && (wb_addr == rs2_addr)) begin
      rs2_data = wb_data;
    end
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end
  end

  reg_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .issue_en (issue_en),
    .issue_rd (issue_rd),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

  assign hazard = rs1_busy | rs2_busy;

endmodule
